spatz_tcdm_responder: RTL

Memory-side responder for the scalar FP load/store port: it serves the `data_q*`/`data_p*` request/response channel that the FP sequencer's LSU drives. The block owns a local word-addressed memory, applies byte-strobed writes, and returns read data tagged with the request ID after a fixed pipeline latency. A response FIFO and a credit counter provide backpressure. It is the bench-side and cluster-side counterpart of the FP LSU, and is used both as a standalone scratchpad and as the memory model in sequencer testbenches.

---
 rtl/spatz_pkg.sv | 25 ++
 rtl/fifo_v3.sv | 72 +++++++
 rtl/spatz_tcdm_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/spatz_pkg.sv
// Shared types and width helpers for the Spatz TCDM responder.
package spatz_pkg;

    localparam int unsigned FLEN       = 64;
    localparam int unsigned MaxIdWidth = 8;

    function automatic int unsigned word_idx_width(input int unsigned num_words);
        return $clog2(num_words);
    endfunction

    function automatic int unsigned byte_off_width(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int unsigned WordIdxWidth = word_idx_width(256);
    localparam int unsigned ByteOffWidth = byte_off_width(FLEN);

    // Response payload sized for the widest configuration; narrower builds zero-extend.
    typedef struct packed {
        logic [FLEN-1:0]       data;
        logic [MaxIdWidth-1:0] id;
        logic                  err;
    } tcdm_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Small FIFO with optional fall-through (empty FIFO forwards a push on the same cycle).
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 2,
    parameter type         dtype        = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AddrDepth-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AddrDepth:0]   cnt_q, cnt_d;
    logic                 mem_we;
    dtype                 mem_q [DEPTH];

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        full_o  = (cnt_q == (AddrDepth+1)'(DEPTH));
        empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
        data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rptr_q];

        if (push_i && !full_o) begin
            mem_we = 1'b1;
            wptr_d = (wptr_q == AddrDepth'(DEPTH - 1)) ? '0 : wptr_q + AddrDepth'(1);
            cnt_d  = cnt_q + (AddrDepth+1)'(1);
        end
        if (pop_i && !empty_o) begin
            rptr_d = (rptr_q == AddrDepth'(DEPTH - 1)) ? '0 : rptr_q + AddrDepth'(1);
            cnt_d  = cnt_d - (AddrDepth+1)'(1);
        end
        // Pushed word is consumed straight through; nothing is stored.
        if (FALL_THROUGH && (cnt_q == '0) && push_i && pop_i) begin
            mem_we = 1'b0;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
        end
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            if (mem_we) mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/spatz_tcdm_responder.sv
// Memory-side responder for the FP LSU data channel: strobed writes, latency-pipelined tagged reads.
// Define SPATZ_TCDM_RESP_ERR_EN to flag addresses beyond the memory as errors instead of wrapping.
module spatz_tcdm_responder
    import spatz_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NumWords  = 256,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RespDepth = 2,
    parameter int unsigned IdWidth   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [AddrWidth-1:0]   data_qaddr_i,
    input  logic                   data_qwrite_i,
    input  logic [3:0]             data_qamo_i,
    input  logic [DataWidth-1:0]   data_qdata_i,
    input  logic [DataWidth/8-1:0] data_qstrb_i,
    input  logic [IdWidth-1:0]     data_qid_i,
    input  logic                   data_qvalid_i,
    output logic                   data_qready_o,
    output logic [DataWidth-1:0]   data_pdata_o,
    output logic                   data_perror_o,
    output logic [IdWidth-1:0]     data_pid_o,
    output logic                   data_pvalid_o,
    input  logic                   data_pready_i
);

    localparam int unsigned ByteOffW  = byte_off_width(DataWidth);
    localparam int unsigned WordIdxW  = word_idx_width(NumWords);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = $clog2(RespDepth + 1);

    logic                 ready_q;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 req_fire, rd_fire, wr_fire, resp_fire;
    logic [WordIdxW-1:0]  word_idx;
    logic                 addr_oob;
    logic                 req_unused, resp_unused;
    tcdm_resp_t           rd_resp;
    tcdm_resp_t           pipe_q [Latency];
    logic [Latency-1:0]   pipe_vld_q;
    tcdm_resp_t           fifo_out;
    logic                 fifo_empty, fifo_full_unused;
    logic [DataWidth-1:0] mem_q [NumWords];

    // AMO opcodes are accepted but serviced as plain accesses.
    assign req_unused = ^{data_qaddr_i, data_qamo_i};
    assign word_idx   = data_qaddr_i[WordIdxW+ByteOffW-1:ByteOffW];

`ifdef SPATZ_TCDM_RESP_ERR_EN
    assign addr_oob = |data_qaddr_i[AddrWidth-1:WordIdxW+ByteOffW];
`else
    assign addr_oob = 1'b0;
`endif

    assign req_fire  = data_qvalid_i && ready_q;
    assign rd_fire   = req_fire && !data_qwrite_i;
    assign wr_fire   = req_fire && data_qwrite_i && !addr_oob;
    assign resp_fire = data_pvalid_o && data_pready_i;

    // Data array carries no reset.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (data_qstrb_i[b]) mem_q[word_idx][b*8 +: 8] <= data_qdata_i[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_resp      = '0;
        rd_resp.data = addr_oob ? '0 : FLEN'(mem_q[word_idx]);
        rd_resp.id   = MaxIdWidth'(data_qid_i);
        rd_resp.err  = addr_oob;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(Latency); i++) pipe_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= rd_fire;
            if (rd_fire) pipe_q[0] <= rd_resp;
            for (int i = 1; i < int'(Latency); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_q[i]     <= pipe_q[i-1];
            end
        end
    end

    // Credits bound in-flight reads to RespDepth, so the FIFO can never overflow.
    fifo_v3 #(
        .FALL_THROUGH (1'b1),
        .DEPTH        (RespDepth),
        .dtype        (tcdm_resp_t)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty),
        .data_i  (pipe_q[Latency-1]),
        .push_i  (pipe_vld_q[Latency-1]),
        .data_o  (fifo_out),
        .pop_i   (resp_fire)
    );

    assign resp_unused   = ^{fifo_out.data, fifo_out.id};
    assign data_pvalid_o = !fifo_empty;
    assign data_pdata_o  = fifo_out.data[DataWidth-1:0];
    assign data_pid_o    = fifo_out.id[IdWidth-1:0];
`ifdef SPATZ_TCDM_RESP_ERR_EN
    assign data_perror_o = fifo_out.err;
`else
    assign data_perror_o = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        unique case ({rd_fire, resp_fire})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Ready is precomputed from next credit count so it never depends on data_pready_i combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d < CntWidth'(RespDepth));
        end
    end

    assign data_qready_o = ready_q;

endmodule
